// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: drives one external full adder LSB first, one bit per clock,
// and collects the sum/carry into held result registers with a start/busy/done handshake.
`timescale 1ns/1ps
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             iCLK_50,
  input  logic             iRST_N,
  input  logic             iSTART,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iCIN,
  output logic             oFA_A,
  output logic             oFA_B,
  output logic             oFA_CIN,
  input  logic             iFA_S,
  input  logic             iFA_COUT,
  output logic             oBUSY,
  output logic             oDONE,
  output logic [WIDTH-1:0] oSUM,
  output logic             oCOUT
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run, last;

  assign run  = (state_q == S_RUN);
  assign last = (cnt_q == CW'(WIDTH-1));

  // Adder inputs come straight from registers, so iFA_* never loops back combinationally.
  assign oFA_A   = run & a_q[0];
  assign oFA_B   = run & b_q[0];
  assign oFA_CIN = run & carry_q;
  assign oBUSY   = run;
  assign oDONE   = (state_q == S_DONE);
  assign oSUM    = sum_q;
  assign oCOUT   = cout_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (iSTART) begin
          a_d     = iA;
          b_d     = iB;
          carry_d = iCIN;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        s_d     = {iFA_S, s_q[WIDTH-1:1]};
        carry_d = iFA_COUT;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          sum_d   = {iFA_S, s_q[WIDTH-1:1]};
          cout_d  = iFA_COUT;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: behavioural full adder, operation-level reference model,
// per-cycle output compare plus directed literal checks.
`timescale 1ns/1ps
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic fa_a, fa_b, fa_cin, fa_s, fa_cout, busy, done, cout;
  logic [W-1:0] sum;

  int tests = 0, fails = 0;
  int done_cnt = 0, cyc = 0;
  bit t6 = 1'b0;

  always #10 clk = ~clk;

  // Full adder behaviour.
  assign fa_s    = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .iCLK_50(clk), .iRST_N(rst_n), .iSTART(start), .iA(a), .iB(b), .iCIN(cin),
    .oFA_A(fa_a), .oFA_B(fa_b), .oFA_CIN(fa_cin), .iFA_S(fa_s), .iFA_COUT(fa_cout),
    .oBUSY(busy), .oDONE(done), .oSUM(sum), .oCOUT(cout));

  // Reference: an op accepted when idle keeps the adder busy W cycles, then reports for one cycle.
  int           m_run;
  bit           m_done;
  logic [W-1:0] m_sum, cap_a, cap_b;
  logic         m_cout, cap_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 0; m_done <= 1'b0; m_sum <= '0; m_cout <= 1'b0;
      cap_a <= '0; cap_b <= '0; cap_c <= 1'b0;
    end else if (m_run == 0 && !m_done) begin
      if (start) begin
        m_run <= W; cap_a <= a; cap_b <= b; cap_c <= cin;
      end
    end else if (m_run > 0) begin
      m_run <= m_run - 1;
      if (m_run == 1) begin
        m_done <= 1'b1;
        {m_cout, m_sum} <= (W+1)'(cap_a) + (W+1)'(cap_b) + (W+1)'(cap_c);
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  function automatic logic [2:0] exp_fa();
    int i;
    logic [63:0] msk, part;
    if (m_run == 0) return 3'b000;
    i    = W - m_run;
    msk  = (64'd1 << i) - 64'd1;
    part = (64'(cap_a) & msk) + (64'(cap_b) & msk) + 64'(cap_c);
    return {cap_a[i], cap_b[i], part[i]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        input logic [W-1:0] es, input logic ec, input string nm, input bit timing);
    int n, nb, nd;
    @(negedge clk); a = ia; b = ib; cin = ic; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 1; nb = 0; nd = -1;
    while (n < 30) begin
      if (busy) nb++;
      if (done) begin nd = n; break; end
      @(negedge clk); n++;
    end
    if (nd < 0) chk({nm, "_timeout"}, 64'(n), 64'd0);
    chk({nm, "_sum"}, 64'(sum), 64'(es));
    chk({nm, "_cout"}, 64'(cout), 64'(ec));
    if (timing) begin
      chk({nm, "_done_cycle"}, 64'(nd), 64'd9);
      chk({nm, "_busy_cycles"}, 64'(nb), 64'(W));
    end
    @(negedge clk);
  endtask

  initial begin
    int base, last_done, n;
    logic [W-1:0] s_prev;
    logic         c_prev;
    last_done = -1;
    fork
      forever begin
        @(negedge clk);
        cyc++;
        chk("cyc_busy", 64'(busy), 64'(m_run > 0));
        chk("cyc_done", 64'(done), 64'(m_done));
        chk("cyc_sum", 64'(sum), 64'(m_sum));
        chk("cyc_cout", 64'(cout), 64'(m_cout));
        chk("cyc_fa", 64'({fa_a, fa_b, fa_cin}), 64'(exp_fa()));
        if (done) begin
          done_cnt++;
          if (t6 && last_done >= 0) chk("t6_period", 64'(cyc - last_done), 64'd10);
          last_done = cyc;
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_fa", 64'({fa_a, fa_b, fa_cin}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "t1", 1'b1);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t2", 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "t3", 1'b0);

    // T4: stray starts and operand changes during RUN.
    base = done_cnt;
    @(negedge clk); a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0; a = 8'hF0; b = 8'h0F;
    @(negedge clk); start = 1'b1; cin = 1'b1;
    @(negedge clk); start = 1'b0; a = 8'h77;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    chk("t4_sum", 64'(sum), 64'h33);
    chk("t4_cout", 64'(cout), 64'd0);
    chk("t4_done_count", 64'(done_cnt - base), 64'd1);

    // T5: reset at RUN edge 4 aborts with outputs cleared.
    @(negedge clk); a = 8'h40; b = 8'h40; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_sum", 64'(sum), 64'd0);
    chk("t5_cout", 64'(cout), 64'd0);
    chk("t5_fa", 64'({fa_a, fa_b, fa_cin}), 64'd0);
    base = done_cnt;
    @(negedge clk); rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("t5_no_done", 64'(done_cnt - base), 64'd0);
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "t5_next", 1'b1);

    // T6: start held high, operands churn every cycle; model checks each result.
    base = done_cnt; t6 = 1'b1; last_done = -1; n = 0;
    s_prev = sum; c_prev = cout;
    @(negedge clk); start = 1'b1;
    while (done_cnt - base < 1000 && n < 10200) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge clk); n++;
    end
    start = 1'b0; t6 = 1'b0;
    chk("t6_ops", 64'(done_cnt - base), 64'd1000);
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
